// File: rtl/enc_pkg.sv
// Shared constants, state encoding and bit helpers for the 16-to-4 encoder
// serializer and its priority-encoder tree.
package enc_pkg;

  localparam int N = 16;
  localparam int W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Clears the lowest set bit; result is zero iff at most one bit was set.
  function automatic logic [N-1:0] lowbit_clear(input logic [N-1:0] vec);
    return vec & (vec - {{(N-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/prio_enc16x4.sv
// Combinational 16-to-4 priority encoder, lowest index wins. Two levels of
// 4-input encoders, mirroring the 2x4 structure of the 4-to-16 decoder.
module prio_enc16x4
  import enc_pkg::*;
(
  input  logic [N-1:0] vec,
  output logic [W-1:0] code,
  output logic         any
);

  // Returns {any, index} of the lowest set bit of a 4-bit group.
  function automatic logic [2:0] pe4(input logic [3:0] v);
    logic [2:0] r;
    r = 3'b000;
    if (v[0])      r = 3'b100;
    else if (v[1]) r = 3'b101;
    else if (v[2]) r = 3'b110;
    else if (v[3]) r = 3'b111;
    return r;
  endfunction

  logic [3:0] grp_any;
  logic [1:0] grp_idx [4];
  logic [1:0] grp_sel;

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      {grp_any[g], grp_idx[g]} = pe4(vec[g*4 +: 4]);
    end
  end

  // An empty vector selects group 0 whose index is 0, so code is 0 too.
  always_comb begin
    {any, grp_sel} = pe4(grp_any);
    code           = {grp_sel, grp_idx[grp_sel]};
  end

endmodule

// File: rtl/enc16x4_serializer.sv
// Accepts a multi-hot request vector and emits the index of every set bit,
// lowest first, one per out_valid/out_ready handshake.
module enc16x4_serializer #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         zero_seen,
  output logic         busy
);

  import enc_pkg::*;

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         zero_q, zero_d;
  logic [W-1:0] enc_code;
  logic         enc_any;
  logic         last_bit;

  prio_enc16x4 u_prio (
    .vec  (pending_q),
    .code (enc_code),
    .any  (enc_any)
  );

  assign last_bit = (lowbit_clear(pending_q) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_d = in_vec;
            state_d   = EMIT;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        // Returning to IDLE only after the handshake gives a one-cycle bubble.
        if (out_ready) begin
          pending_d = lowbit_clear(pending_q);
          if (last_bit) state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // Code and last flag are forced low outside EMIT so idle outputs are clean.
  assign out_code  = (out_valid && enc_any) ? enc_code : '0;
  assign out_last  = out_valid && last_bit;
  assign zero_seen = zero_q;

endmodule

// File: tb/tb_enc16x4_serializer.sv
// Scoreboard bench for enc16x4_serializer: directed cases plus random vectors.
module tb_enc16x4_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_code;
  logic        out_last;
  logic        zero_seen;
  logic        busy;

  enc16x4_serializer #(.N(16), .W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .zero_seen (zero_seen),
    .busy      (busy)
  );

  typedef struct packed {
    logic [3:0] code;
    logic       last;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] vec_q[$];
  logic [15:0] acc;
  int          checks;
  int          errors;
  int          ready_mode;
  logic        hold_prev;
  logic [3:0]  prev_code;
  logic        prev_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: each set bit in ascending order, last flag on the highest.
  task automatic expect_vec(input logic [15:0] v);
    int hi;
    hi = -1;
    for (int i = 0; i < 16; i++) if (v[i]) hi = i;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) exp_q.push_back('{code: 4'(i), last: (i == hi)});
    end
    if (v != 16'h0) vec_q.push_back(v);
  endtask

  task automatic send(input logic [15:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(n < 500), 32'(1));
    expect_vec(v);
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = 16'($urandom);
    @(negedge clk);
    chk("zero_seen_after_accept", 32'(zero_seen), 32'(v == 16'h0));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 1000), 32'(1));
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every handshake pops the scoreboard; decoded codes rebuild vectors.
  initial begin
    hold_prev = 1'b0;
    prev_code = 4'h0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev && out_valid) begin
          chk("hold_code", 32'(out_code), 32'(prev_code));
          chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        hold_prev = out_valid && !out_ready;
        prev_code = out_code;
        prev_last = out_last;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_code", 32'(out_code), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_code", 32'(out_code), 32'(e.code));
            chk("out_last", 32'(out_last), 32'(e.last));
            acc = acc | 16'(16'h1 << out_code);
            if (out_last) begin
              if (vec_q.size() == 0) begin
                chk("last_without_vector", 32'(0), 32'(1));
              end else begin
                chk("decoded_or", 32'(acc), 32'(vec_q.pop_front()));
              end
              acc = 16'h0;
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [15:0] v;
    checks     = 0;
    errors     = 0;
    ready_mode = 0;
    acc        = 16'h0;
    in_valid   = 1'b0;
    in_vec     = 16'h0;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    #10;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_zero_seen", 32'(zero_seen), 32'(0));
    chk("rst_out_code", 32'(out_code), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));

    // 0x0421: codes 0, 5, 10 back to back, then one bubble cycle.
    send(16'h0421);
    chk("v421_c0_valid", 32'(out_valid), 32'(1));
    chk("v421_c0_code", 32'(out_code), 32'(0));
    chk("v421_c0_last", 32'(out_last), 32'(0));
    chk("v421_in_ready_busy", 32'(in_ready), 32'(0));
    @(negedge clk);
    chk("v421_c1_code", 32'(out_code), 32'(5));
    chk("v421_c1_last", 32'(out_last), 32'(0));
    @(negedge clk);
    chk("v421_c2_code", 32'(out_code), 32'(10));
    chk("v421_c2_last", 32'(out_last), 32'(1));
    @(negedge clk);
    chk("v421_done_valid", 32'(out_valid), 32'(0));
    chk("v421_done_in_ready", 32'(in_ready), 32'(1));
    chk("v421_done_busy", 32'(busy), 32'(0));
    wait_idle();

    // 0xFFFF under alternating back-pressure.
    ready_mode = 1;
    send(16'hFFFF);
    wait_idle();
    ready_mode = 0;
    @(negedge clk);

    // All-zero vector: a single zero_seen pulse and no codes.
    send(16'h0000);
    chk("zero_out_valid", 32'(out_valid), 32'(0));
    chk("zero_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    chk("zero_pulse_end", 32'(zero_seen), 32'(0));
    chk("zero_out_valid2", 32'(out_valid), 32'(0));

    // 0x8000 held by back-pressure while 0x0001 is offered and refused.
    ready_mode = 3;
    @(negedge clk);
    @(negedge clk);
    send(16'h8000);
    chk("v8000_code", 32'(out_code), 32'(15));
    chk("v8000_last", 32'(out_last), 32'(1));
    chk("v8000_in_ready", 32'(in_ready), 32'(0));
    expect_vec(16'h0001);
    in_valid = 1'b1;
    in_vec   = 16'h0001;
    repeat (3) @(negedge clk);
    chk("ignored_in_ready", 32'(in_ready), 32'(0));
    chk("ignored_code", 32'(out_code), 32'(15));
    chk("ignored_busy", 32'(busy), 32'(1));
    ready_mode = 0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("late_accept_wait", 32'(n < 50), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();

    // Reset asserted after two of the four codes of 0x00F0.
    send(16'h00F0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_out_last", 32'(out_last), 32'(0));
    chk("mid_rst_remaining", 32'(exp_q.size()), 32'(2));
    exp_q.delete();
    vec_q.delete();
    acc = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_busy", 32'(busy), 32'(0));
    chk("after_rst_out_valid", 32'(out_valid), 32'(0));
    chk("after_rst_in_ready", 32'(in_ready), 32'(1));
    chk("after_rst_out_code", 32'(out_code), 32'(0));
    chk("after_rst_pending", 32'(dut.pending_q), 32'(0));

    // Random vectors with random back-pressure.
    ready_mode = 2;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0:       v = 16'h0;
        1:       v = 16'(16'h1 << $urandom_range(0, 15));
        default: v = 16'($urandom);
      endcase
      send(v);
    end
    wait_idle();
    chk("final_exp_empty", 32'(exp_q.size()), 32'(0));
    chk("final_vec_empty", 32'(vec_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
